// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: drives the IorD select, waits out memory read latency,
// performs read-modify-write for sub-word stores and extracts/extends loaded data.
module mem_access_seq #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [2:0]  req_src,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  iord_sel,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e          state_q;
    logic            write_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic [2:0]      src_q;
    logic [1:0]      addr_q;
    logic [15:0]     wdata_q;
    logic [CntW-1:0] cnt_q;

    logic            req_err;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic [31:0]     merge_val;

    assign req_err = (req_size == 2'b11) ||
                     (req_size == 2'b00 && addr_lo != 2'b00) ||
                     (req_size == 2'b01 && addr_lo[0]);

    // Select follows the incoming request in the accept cycle so the address is ready at T0.
    assign iord_sel = (state_q == StIdle && req_valid && !reset) ? req_src : src_q;

    always_comb begin
        rd_byte   = mem_rdata[{addr_q, 3'b000} +: 8];
        rd_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val  = mem_rdata;
        merge_val = mem_rdata;
        unique case (size_q)
            2'b01: begin
                load_val = {{16{sign_q & rd_half[15]}}, rd_half};
                merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            2'b10: begin
                load_val = {{24{sign_q & rd_byte[7]}}, rd_byte};
                merge_val[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            default: begin
                load_val  = mem_rdata;
                merge_val = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            src_q     <= 3'd0;
            addr_q    <= 2'b00;
            wdata_q   <= 16'h0;
            cnt_q     <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        sign_q  <= req_sign;
                        src_q   <= req_src;
                        addr_q  <= addr_lo;
                        wdata_q <= wdata[15:0];
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        if (req_err) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else if (req_write && req_size == 2'b00) begin
                            state_q   <= StWrite;
                            mem_wr    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    // mem_rdata is valid only in the last READ cycle.
                    if (cnt_q == CntLast) begin
                        if (write_q) begin
                            state_q   <= StWrite;
                            mem_wr    <= 1'b1;
                            mem_wdata <= merge_val;
                        end else begin
                            state_q <= StDone;
                            rdata   <= load_val;
                            done    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWrite: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized bench for mem_access_seq: a per-transaction timeline model drives expectations
// that a negedge compare process checks every cycle, plus literal checks of directed cases.
module tb_mem_access_seq;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_sign;
    logic [1:0]  req_size, addr_lo;
    logic [2:0]  req_src;
    logic [31:0] wdata, mem_rdata;
    logic [2:0]  iord_sel;
    logic        mem_wr, busy, done, err;
    logic [31:0] mem_wdata, rdata;

    mem_access_seq #(.MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_src   (req_src),
        .addr_lo   (addr_lo),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .iord_sel  (iord_sel),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic [2:0]  e_iord;
    logic        e_busy, e_wr, e_done, e_err;
    logic [31:0] e_wdata, e_rdata;

    // Model state carried between transactions.
    logic [31:0] m_rdata = 32'h0;
    logic [2:0]  m_src   = 3'd0;

    int          cur_k   = -1;
    int          done_k  = -1;
    int          wr_cnt  = 0;
    logic [31:0] last_wr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr) begin
            wr_cnt++;
            last_wr = mem_wdata;
        end
        if (done) done_k = cur_k;
        if (chk_en) begin
            chk("iord_sel", {29'd0, iord_sel}, {29'd0, e_iord});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("err", {31'd0, err}, {31'd0, e_err});
            chk("rdata", rdata, e_rdata);
            if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        req_write = 1'($urandom);
        req_size  = 2'($urandom);
        req_sign  = 1'($urandom);
        req_src   = 3'($urandom_range(0, 4));
        addr_lo   = 2'($urandom);
        wdata     = $urandom();
        mem_rdata = $urandom();
    endtask

    task automatic set_idle();
        rand_fields();
        req_valid = 1'b0;
        cur_k     = -1;
        e_iord    = m_src;
        e_busy    = 1'b0;
        e_wr      = 1'b0;
        e_done    = 1'b0;
        e_err     = 1'b0;
        e_rdata   = m_rdata;
        e_wdata   = 32'h0;
    endtask

    task automatic idle_cycle();
        next_cycle();
        set_idle();
    endtask

    // Issue one request in the current (idle) cycle; returns in the idle cycle after done.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [2:0] src, input logic [1:0] alo,
                           input logic [31:0] wd, input logic [31:0] mw);
        logic        bad;
        int          wr_t, done_t, shift;
        logic [31:0] wmask, lane, new_rd, wr_val;
        bad    = (sz == 2'd3) || (sz == 2'd0 && alo != 2'd0) || (sz == 2'd1 && alo[0]);
        wr_t   = -1;
        new_rd = m_rdata;
        wr_val = 32'h0;
        wmask  = (sz == 2'd1) ? 32'h0000_FFFF : (sz == 2'd2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        shift  = (sz == 2'd1) ? 16 * int'(alo[1]) : (sz == 2'd2) ? 8 * int'(alo) : 0;
        lane   = (mw >> shift) & wmask;
        if (sg && sz == 2'd1 && lane[15]) lane = lane | ~wmask;
        if (sg && sz == 2'd2 && lane[7]) lane = lane | ~wmask;
        if (bad) begin
            done_t = 1;
        end else if (w && sz == 2'd0) begin
            wr_t   = 1;
            done_t = 2;
            wr_val = wd;
        end else if (!w) begin
            done_t = LAT + 1;
            new_rd = lane;
        end else begin
            wr_t   = LAT + 1;
            done_t = LAT + 2;
            wr_val = (mw & ~(wmask << shift)) | ((wd & wmask) << shift);
        end
        for (int k = 0; k <= done_t; k++) begin
            if (k > 0) next_cycle();
            cur_k = k;
            if (k == 0) begin
                req_valid = 1'b1;
                req_write = w;
                req_size  = sz;
                req_sign  = sg;
                req_src   = src;
                addr_lo   = alo;
                wdata     = wd;
                mem_rdata = $urandom();
            end else begin
                rand_fields();
                req_valid = 1'($urandom);
            end
            if (k == LAT) mem_rdata = mw;
            e_iord  = src;
            e_busy  = (k != 0);
            e_wr    = (k == wr_t);
            e_wdata = wr_val;
            e_done  = (k == done_t);
            e_err   = bad && (k == done_t);
            e_rdata = (k >= done_t) ? new_rd : m_rdata;
        end
        m_rdata = new_rd;
        m_src   = src;
        idle_cycle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iord"}, {29'd0, iord_sel}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int wr_before;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_src   = 3'd0;
        addr_lo   = 2'b00;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        #1 reset = 1'b1;
        #2 chk_reset_vals("por");
        next_cycle();
        next_cycle();
        reset = 1'b0;
        set_idle();
        chk_en = 1'b1;
        idle_cycle();

        // Word load.
        run_req(1'b0, 2'b00, 1'b0, 3'd1, 2'b00, 32'h0, 32'hDEADBEEF);
        chk("lit_word_load", rdata, 32'hDEADBEEF);
        chk("lit_word_load_T", done_k, 3);
        // Signed and unsigned byte load, lane 3.
        run_req(1'b0, 2'b10, 1'b1, 3'd2, 2'b11, 32'h0, 32'h80123456);
        chk("lit_sbyte_load", rdata, 32'hFFFFFF80);
        run_req(1'b0, 2'b10, 1'b0, 3'd2, 2'b11, 32'h0, 32'h80123456);
        chk("lit_ubyte_load", rdata, 32'h00000080);
        // Halfword store, upper lane.
        wr_before = wr_cnt;
        run_req(1'b1, 2'b01, 1'b0, 3'd3, 2'b10, 32'h0000ABCD, 32'h11223344);
        chk("lit_half_store_data", last_wr, 32'hABCD3344);
        chk("lit_half_store_wrs", wr_cnt - wr_before, 1);
        chk("lit_half_store_T", done_k, 4);
        // Word store followed by an immediate back-to-back accept.
        run_req(1'b1, 2'b00, 1'b0, 3'd4, 2'b00, 32'hCAFEF00D, 32'h0);
        chk("lit_word_store_data", last_wr, 32'hCAFEF00D);
        chk("lit_word_store_T", done_k, 2);
        run_req(1'b0, 2'b00, 1'b0, 3'd0, 2'b00, 32'h0, 32'h01020304);
        // Error requests.
        wr_before = wr_cnt;
        run_req(1'b0, 2'b00, 1'b0, 3'd1, 2'b01, 32'h0, 32'h55555555);
        chk("lit_misalign_T", done_k, 1);
        run_req(1'b1, 2'b11, 1'b0, 3'd2, 2'b00, 32'h12345678, 32'h0);
        chk("lit_reserved_T", done_k, 1);
        chk("lit_err_no_wr", wr_cnt - wr_before, 0);
        chk("lit_err_rdata_kept", rdata, 32'h01020304);

        // Reset during READ of a byte store.
        chk_en    = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_src   = 3'd3;
        addr_lo   = 2'b01;
        wdata     = 32'h000000AA;
        next_cycle();
        req_valid = 1'b0;
        wr_before = wr_cnt;
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_read");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("rst_hold_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            chk("rst_after_done", {31'd0, done}, 32'd0);
        end
        chk("rst_no_wr", wr_cnt - wr_before, 0);
        m_rdata = 32'h0;
        m_src   = 3'd0;
        set_idle();
        chk_en = 1'b1;
        idle_cycle();
        run_req(1'b0, 2'b00, 1'b0, 3'd2, 2'b00, 32'h0, 32'h0BADF00D);
        chk("lit_load_after_rst", rdata, 32'h0BADF00D);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_req(1'($urandom), sz, 1'($urandom), 3'($urandom_range(0, 4)), 2'($urandom),
                    $urandom(), $urandom());
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multicycle memory access sequencer for the 32-bit datapath. It accepts one load/store request at a time and drives the 3-bit select of the address-source mux (IorD). It waits out the fixed memory read latency and drives the memory write strobe. Byte and halfword stores use read-modify-write; loaded data is returned extracted and extended. It sits between the control unit and the unified instruction/data memory, consuming the address the IorD mux produces.

## Interface
- MEM_LAT, 2, memory read latency in cycles (≥1); mem_rdata is valid in the MEM_LAT-th cycle after the address is applied
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe, sampled only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved
- req_sign  in  1  load extension: 1 sign-extend, 0 zero-extend
- req_src  in  3  address source 0–4 forwarded to the IorD mux
- addr_lo  in  2  bits [1:0] of the IorD mux output
- wdata  in  32  store data, right-aligned
- mem_rdata  in  32  memory read data
- iord_sel  out  3  select for the IorD mux
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- rdata  out  32  load result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or reserved request

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - iord_sel = req_src when req_valid = 1, else the held value.
  - On req_valid = 1 the block latches req_write, req_size, req_sign, req_src, addr_lo and wdata (accept cycle T0).
- Error check at accept:
  - size 11, word with addr_lo ≠ 00, or halfword with addr_lo[0] = 1 sets err.
  - Next state is DONE. No memory access occurs and mem_wr stays 0.
- Load, or byte/half store: enter READ and count MEM_LAT cycles. At the end of the last READ cycle, capture mem_rdata into an internal word register.
- Load:
  - Byte lane k = addr_lo; the lane is at bits [8k+7:8k] (little-endian).
  - A halfword uses lane pair addr_lo[1].
  - Extend per req_sign into rdata, then go to DONE.
- Word store: go directly from IDLE to WRITE with mem_wdata = wdata.
- Sub-word store: after READ, go to WRITE with mem_wdata = captured word, where only the addressed byte or halfword lane is replaced by wdata[7:0] or wdata[15:0].
- WRITE: mem_wr = 1 for exactly one cycle, then DONE.
- DONE:
  - done = 1 for one cycle; err is valid in this cycle.
  - Next state is IDLE. req_valid in the DONE cycle is ignored.
- iord_sel is held at the latched req_src from T0 through DONE.
- rdata holds its value until the next completed load.

## Timing
- Reset (async, immediate) puts the block in IDLE with iord_sel = 0, mem_wr = 0, mem_wdata = 0, rdata = 0, busy = 0, done = 0, err = 0.
- Cycles are counted from accept T0:
  - Load: READ T1..T_MEM_LAT, done at T_(MEM_LAT+1). With MEM_LAT = 2, done at T3.
  - Word store: mem_wr at T1, done at T2.
  - Sub-word store: READ T1..T_MEM_LAT, mem_wr at T_(MEM_LAT+1), done at T_(MEM_LAT+2).
  - Error: done = err = 1 at T1.
- err returns to 0 the cycle after done.
- The earliest back-to-back accept is the cycle after done.
- mem_wr is never high in READ, DONE or IDLE. It is never high two consecutive cycles.
- Reset during READ or WRITE clears mem_wr immediately. No done pulse is produced for the aborted request.

## Test plan
- Word load, MEM_LAT = 2, req_src = 1, addr_lo = 00, mem_rdata = 0xDEADBEEF:
  - iord_sel = 1 from T0.
  - done at T3 with rdata = 0xDEADBEEF, err = 0, mem_wr never asserted.
- Signed byte load, addr_lo = 11, mem_rdata = 0x80123456: rdata = 0xFFFFFF80. With req_sign = 0: rdata = 0x00000080.
- Halfword store, addr_lo = 10, wdata = 0x0000ABCD, mem_rdata = 0x11223344:
  - mem_wr only at T3 with mem_wdata = 0xABCD3344.
  - done at T4.
- Word store, wdata = 0xCAFEF00D: mem_wr at T1 with mem_wdata = 0xCAFEF00D, done at T2. A req_valid held high is accepted again at T3.
- Misaligned word load, addr_lo = 01, and size 11 request: each gives done = err = 1 at T1 with mem_wr = 0.
- Reset asserted during READ of a sub-word store:
  - All outputs go to reset values immediately and no mem_wr occurs.
  - A new word load after reset completes normally.
